// File: rtl/ram_string_reader_pkg.sv
`default_nettype none
// ============================================================================
//  ram_stream_pkg
//  Shared widths, FSM state, word classes and error codes for the string reader.
//  Revision: 1.0
// ============================================================================
package ram_stream_pkg;

   localparam int RAM_ADDR_W = 10;
   localparam int RAM_WORD_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      WC_CHAR   = 2'd0,
      WC_TERM   = 2'd1,
      WC_BADTAG = 2'd2
   } word_class_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_TAG  = 2'b01;
   localparam logic [1:0] ERR_LEN  = 2'b10;
   localparam logic [1:0] ERR_WRAP = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ram_string_reader_if.sv
`default_nettype none
// ============================================================================
//  ram_string_reader_if
//  RAM read port plus valid/ready character stream of the string reader.
//  Revision: 1.0
// ============================================================================
interface ram_string_reader_if #(
   parameter int ADDR_W = 10,
   parameter int WORD_W = 10
) ();

   logic [ADDR_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_rdata;
   logic [7:0]        char_data;
   logic              char_valid;
   logic              char_ready;

   modport master (
      output mem_addr,
      input  mem_rdata,
      output char_data,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  mem_addr,
      output mem_rdata,
      input  char_data,
      input  char_valid,
      output char_ready
   );

endinterface
`default_nettype wire

// File: rtl/ram_string_reader_classify.sv
`default_nettype none
// ============================================================================
//  ram_word_classify
//  Splits a RAM word into terminator / bad-tag / character and its byte.
//  Revision: 1.0
// ============================================================================
module ram_word_classify
   import ram_stream_pkg::*;
#(
   parameter int WORD_W = RAM_WORD_W
) (
   input  logic [WORD_W-1:0] word,
   output word_class_t       word_class,
   output logic [7:0]        char_byte
);

   always_comb begin
      char_byte = word[7:0];
      if (word == '0) begin
         word_class = WC_TERM;
      end else if (word[WORD_W-1:8] != '0) begin
         word_class = WC_BADTAG;
      end else begin
         word_class = WC_CHAR;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ram_string_reader.sv
`default_nettype none
// ============================================================================
//  ram_string_reader
//  Walks RAM from start_addr and streams character bytes until a zero word.
//  Revision: 1.0
// ============================================================================
module ram_string_reader
   import ram_stream_pkg::*;
#(
   parameter int ADDR_W  = RAM_ADDR_W,
   parameter int WORD_W  = RAM_WORD_W,
   parameter int MAX_LEN = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   ram_string_reader_if.master bus,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [1:0]          err_code,
   output logic [8:0]          char_count
);

   localparam logic [8:0]      MAX_CNT = 9'(MAX_LEN);
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic [8:0]        count_q, count_d;
   logic [7:0]        char_data_q, char_data_d;
   logic              char_valid_q, char_valid_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        err_code_q, err_code_d;

   word_class_t       word_class;
   logic [7:0]        char_byte;
   logic              fetch_en;

   ram_word_classify #(
      .WORD_W     (WORD_W)
   ) u_classify (
      .word       (bus.mem_rdata),
      .word_class (word_class),
      .char_byte  (char_byte)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         count_q      <= '0;
         char_data_q  <= 8'h00;
         char_valid_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         count_q      <= count_d;
         char_data_q  <= char_data_d;
         char_valid_q <= char_valid_d;
         done_q       <= done_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   // Next state. FETCH and an accepted SEND share the same word evaluation.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      count_d      = count_q;
      char_data_d  = char_data_q;
      char_valid_d = char_valid_q;
      done_d       = 1'b0;
      err_d        = err_q;
      err_code_d   = err_code_q;
      fetch_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               ptr_d      = {1'b0, start_addr};
               count_d    = '0;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
               state_d    = FETCH;
            end
         end
         FETCH: begin
            fetch_en = 1'b1;
         end
         SEND: begin
            if (char_valid_q && bus.char_ready) begin
               char_valid_d = 1'b0;
               fetch_en     = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (fetch_en) begin
         state_d = IDLE;
         // Pointer past the top of RAM: the word at mem_addr is not a real fetch.
         if (ptr_q[ADDR_W]) begin
            err_d      = 1'b1;
            err_code_d = ERR_WRAP;
         end else begin
            case (word_class)
               WC_TERM: begin
                  done_d = 1'b1;
               end
               WC_BADTAG: begin
                  err_d      = 1'b1;
                  err_code_d = ERR_TAG;
               end
               default: begin
                  if (count_q == MAX_CNT) begin
                     err_d      = 1'b1;
                     err_code_d = ERR_LEN;
                  end else begin
                     char_data_d  = char_byte;
                     char_valid_d = 1'b1;
                     ptr_d        = ptr_q + PTR_ONE;
                     count_d      = count_q + 9'd1;
                     state_d      = SEND;
                  end
               end
            endcase
         end
      end
   end

   // Outputs
   always_comb begin
      bus.mem_addr   = ptr_q[ADDR_W-1:0];
      bus.char_data  = char_data_q;
      bus.char_valid = char_valid_q;
      busy           = (state_q != IDLE);
      done           = done_q;
      err            = err_q;
      err_code       = err_code_q;
      char_count     = count_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_ram_string_reader.sv
`default_nettype none
// ============================================================================
//  tb_ram_string_reader
//  Scoreboard bench: two readers (full length and MAX_LEN=4) over one RAM.
//  Revision: 1.0
// ============================================================================
module tb_ram_string_reader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ready;
   logic       start_a, start_b;
   logic [9:0] addr_a, addr_b;
   logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [1:0] code_a, code_b;
   logic [8:0] cnt_a, cnt_b;

   logic [9:0] ram [0:1023];
   logic [7:0] exp_a [$];
   logic [7:0] exp_b [$];

   int checks = 0;
   int failures = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   int ready_mode = 1;
   string s_main = "WafflesAndPancakes";

   always #5 clk = ~clk;

   ram_string_reader_if #(.ADDR_W(10), .WORD_W(10)) bus_a ();
   ram_string_reader_if #(.ADDR_W(10), .WORD_W(10)) bus_b ();

   assign bus_a.mem_rdata  = ram[bus_a.mem_addr];
   assign bus_b.mem_rdata  = ram[bus_b.mem_addr];
   assign bus_a.char_ready = ready;
   assign bus_b.char_ready = ready;

   ram_string_reader #(.ADDR_W(10), .WORD_W(10), .MAX_LEN(256)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .start_addr(addr_a), .bus(bus_a),
      .busy(busy_a), .done(done_a), .err(err_a), .err_code(code_a), .char_count(cnt_a)
   );

   ram_string_reader #(.ADDR_W(10), .WORD_W(10), .MAX_LEN(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .start_addr(addr_b), .bus(bus_b),
      .busy(busy_b), .done(done_b), .err(err_b), .err_code(code_b), .char_count(cnt_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Consumer model
   initial begin
      ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       ready = 1'b0;
            1:       ready = 1'b1;
            default: ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitors: pop expected bytes on each handshake, check stall stability.
   logic       stall_a = 1'b0, stall_b = 1'b0;
   logic [7:0] held_a = 8'h00, held_b = 8'h00;

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_a) begin
            chk("a_stall_valid", 32'(bus_a.char_valid), 32'd1);
            chk("a_stall_data", 32'(bus_a.char_data), 32'(held_a));
         end
         if (bus_a.char_valid && bus_a.char_ready) begin
            if (exp_a.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL a_unexpected_char: got %0h expected none", bus_a.char_data);
            end else begin
               chk("a_char", 32'(bus_a.char_data), 32'(exp_a.pop_front()));
            end
         end
         if (done_a) begin
            done_cnt_a++;
            chk("a_done_err_excl", 32'(err_a), 32'd0);
         end
      end
      stall_a = rst_n && bus_a.char_valid && !bus_a.char_ready;
      held_a  = bus_a.char_data;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_b) begin
            chk("b_stall_valid", 32'(bus_b.char_valid), 32'd1);
            chk("b_stall_data", 32'(bus_b.char_data), 32'(held_b));
         end
         if (bus_b.char_valid && bus_b.char_ready) begin
            if (exp_b.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL b_unexpected_char: got %0h expected none", bus_b.char_data);
            end else begin
               chk("b_char", 32'(bus_b.char_data), 32'(exp_b.pop_front()));
            end
         end
         if (done_b) done_cnt_b++;
      end
      stall_b = rst_n && bus_b.char_valid && !bus_b.char_ready;
      held_b  = bus_b.char_data;
   end

   task automatic push_main(input bit sel, input int n);
      for (int i = 0; i < n; i++) begin
         if (sel) exp_b.push_back(s_main[i]);
         else     exp_a.push_back(s_main[i]);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the start edge.
   task automatic pulse_start(input bit sel, input logic [9:0] a);
      if (sel) begin start_b = 1'b1; addr_b = a; end
      else     begin start_a = 1'b1; addr_a = a; end
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_idle(input bit sel, input int max, output int cyc);
      cyc = 0;
      @(negedge clk);
      while ((sel ? busy_b : busy_a) && cyc < max) begin
         cyc++;
         @(negedge clk);
      end
      if (sel ? busy_b : busy_a) begin
         checks++;
         failures++;
         $display("FAIL wait_idle_timeout: busy still 1 after %0d cycles", max);
      end
      @(posedge clk);
      #1;
   endtask

   int cyc;
   int d0;

   initial begin
      rst_n = 1'b0;
      start_a = 1'b0; start_b = 1'b0;
      addr_a = '0;    addr_b = '0;
      for (int i = 0; i < 1024; i++) ram[i] = 10'h000;
      for (int i = 0; i < 18; i++) ram[3+i] = {2'b00, s_main[i]};
      ram[1]    = 10'h240;
      ram[1023] = 10'h041;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(bus_a.char_valid), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      chk("rst_done", 32'(done_a), 32'd0);
      chk("rst_err", 32'(err_a), 32'd0);
      chk("rst_code", 32'(code_a), 32'd0);
      chk("rst_data", 32'(bus_a.char_data), 32'd0);
      chk("rst_count", 32'(cnt_a), 32'd0);
      chk("rst_addr", 32'(bus_a.mem_addr), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: full string, ready held high
      push_main(1'b0, 18);
      d0 = done_cnt_a;
      pulse_start(1'b0, 10'd3);
      @(negedge clk);
      chk("t1_fetch_valid", 32'(bus_a.char_valid), 32'd0);
      chk("t1_fetch_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
      chk("t1_first_valid", 32'(bus_a.char_valid), 32'd1);
      wait_idle(1'b0, 200, cyc);
      chk("t1_stream_cycles", 32'(cyc), 32'd17);
      chk("t1_done", 32'(done_cnt_a - d0), 32'd1);
      chk("t1_err", 32'(err_a), 32'd0);
      chk("t1_count", 32'(cnt_a), 32'd18);
      chk("t1_drained", 32'(exp_a.size()), 32'd0);

      // 3: bad tag at first word
      d0 = done_cnt_a;
      pulse_start(1'b0, 10'd1);
      wait_idle(1'b0, 50, cyc);
      chk("t3_cycles", 32'(cyc), 32'd1);
      chk("t3_err", 32'(err_a), 32'd1);
      chk("t3_code", 32'(code_a), 32'h1);
      chk("t3_count", 32'(cnt_a), 32'd0);
      chk("t3_no_done", 32'(done_cnt_a - d0), 32'd0);

      // 2: random backpressure, same bytes; error cleared by the new start
      ready_mode = 2;
      push_main(1'b0, 18);
      d0 = done_cnt_a;
      pulse_start(1'b0, 10'd3);
      wait_idle(1'b0, 2000, cyc);
      ready_mode = 1;
      chk("t2_done", 32'(done_cnt_a - d0), 32'd1);
      chk("t2_err", 32'(err_a), 32'd0);
      chk("t2_code", 32'(code_a), 32'h0);
      chk("t2_count", 32'(cnt_a), 32'd18);
      chk("t2_drained", 32'(exp_a.size()), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      // 4: empty string
      pulse_start(1'b0, 10'd21);
      @(negedge clk);
      chk("t4_done_early", 32'(done_a), 32'd0);
      chk("t4_busy", 32'(busy_a), 32'd1);
      @(negedge clk);
      chk("t4_done", 32'(done_a), 32'd1);
      chk("t4_idle", 32'(busy_a), 32'd0);
      chk("t4_count", 32'(cnt_a), 32'd0);
      @(posedge clk);
      #1;

      // 5: length limit of 4
      push_main(1'b1, 4);
      d0 = done_cnt_b;
      pulse_start(1'b1, 10'd3);
      wait_idle(1'b1, 100, cyc);
      chk("t5_err", 32'(err_b), 32'd1);
      chk("t5_code", 32'(code_b), 32'h2);
      chk("t5_count", 32'(cnt_b), 32'd4);
      chk("t5_no_done", 32'(done_cnt_b - d0), 32'd0);
      chk("t5_drained", 32'(exp_b.size()), 32'd0);

      // 6a: address wrap past 1023
      exp_a.push_back(8'h41);
      pulse_start(1'b0, 10'd1023);
      wait_idle(1'b0, 50, cyc);
      chk("t6_err", 32'(err_a), 32'd1);
      chk("t6_code", 32'(code_a), 32'h3);
      chk("t6_count", 32'(cnt_a), 32'd1);
      chk("t6_drained", 32'(exp_a.size()), 32'd0);

      // 6b: reset in the middle of a stalled string, then replay
      push_main(1'b0, 18);
      pulse_start(1'b0, 10'd3);
      repeat (4) @(posedge clk);
      #1 ready_mode = 0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_a.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("t6_rst_valid", 32'(bus_a.char_valid), 32'd0);
      chk("t6_rst_busy", 32'(busy_a), 32'd0);
      ready_mode = 1;
      @(posedge clk);
      #1;
      push_main(1'b0, 18);
      d0 = done_cnt_a;
      pulse_start(1'b0, 10'd3);
      wait_idle(1'b0, 200, cyc);
      chk("t6_replay_done", 32'(done_cnt_a - d0), 32'd1);
      chk("t6_replay_count", 32'(cnt_a), 32'd18);
      chk("t6_replay_err", 32'(err_a), 32'd0);
      chk("t6_replay_drained", 32'(exp_a.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
